bist_pattern_engine: RTL and testbench



---
 rtl/bist_pattern_engine.sv | 138 +++++++++++++
 tb/tb_bist_pattern_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_pattern_engine.sv
// BIST engine: Galois LFSR stimulus into the DUT, MISR compaction of its responses,
// and a golden-signature compare latched when the run completes.
module bist_pattern_engine #(
    parameter int               WIDTH = 8,
    parameter int               NPAT  = 255,
    parameter int               LAT   = 0,
    parameter logic [WIDTH-1:0] SEED  = 8'h01,
    parameter logic [WIDTH-1:0] POLY  = 8'hB8,
    parameter logic [WIDTH-1:0] MPOLY = 8'hB8
) (
    input  logic             C,
    input  logic             R,
    input  logic             START,
    input  logic [WIDTH-1:0] GOLDEN,
    input  logic [WIDTH-1:0] RESP,
    output logic [WIDTH-1:0] STIM,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SIG,
    output logic             PASS
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] SEED_EFF   = (SEED == '0) ? ONE : SEED;
    localparam logic [15:0]      LAST_PAT   = 16'(NPAT - 1);
    localparam logic [15:0]      LAST_FLUSH = 16'(LAT - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] stim_q, stim_next;
    logic [WIDTH-1:0] sig_q, sig_next;
    logic [WIDTH-1:0] misr_step;
    logic [15:0]      cnt, cnt_next;
    logic             pass_q, pass_next;
    logic             capture;

    always_ff @(posedge C) begin
        if (R) begin
            state  <= S_IDLE;
            stim_q <= SEED_EFF;
            sig_q  <= '0;
            cnt    <= '0;
            pass_q <= 1'b0;
        end else begin
            state  <= state_next;
            stim_q <= stim_next;
            sig_q  <= sig_next;
            cnt    <= cnt_next;
            pass_q <= pass_next;
        end
    end

    // The valid pipeline marks which cycles carry a response belonging to a pattern.
    generate
        if (LAT > 0) begin : g_pipe
            logic [LAT-1:0] vpipe;

            always_ff @(posedge C) begin
                if (R) begin
                    vpipe <= '0;
                end else if (state == S_RUN || state == S_FLUSH) begin
                    vpipe[0] <= (state == S_RUN);
                    for (int i = 1; i < LAT; i++) begin
                        vpipe[i] <= vpipe[i-1];
                    end
                end
            end

            assign capture = vpipe[LAT-1];
        end else begin : g_nopipe
            assign capture = (state == S_RUN);
        end
    endgenerate

    assign misr_step = {1'b0, sig_q[WIDTH-1:1]} ^ (sig_q[0] ? MPOLY : '0) ^ RESP;

    always_comb begin
        state_next = state;
        stim_next  = stim_q;
        sig_next   = sig_q;
        cnt_next   = cnt;
        pass_next  = pass_q;

        if (capture) begin
            sig_next = misr_step;
        end

        case (state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_next = S_RUN;
                    stim_next  = SEED_EFF;
                    sig_next   = '0;
                    cnt_next   = '0;
                    pass_next  = 1'b0;
                end
            end
            S_RUN: begin
                stim_next = {1'b0, stim_q[WIDTH-1:1]} ^ (stim_q[0] ? POLY : '0);
                cnt_next  = cnt + 16'd1;
                if (cnt == LAST_PAT) begin
                    cnt_next = '0;
                    if (LAT > 0) begin
                        state_next = S_FLUSH;
                    end else begin
                        state_next = S_DONE;
                        pass_next  = (sig_next == GOLDEN);
                    end
                end
            end
            S_FLUSH: begin
                cnt_next = cnt + 16'd1;
                if (cnt == LAST_FLUSH) begin
                    cnt_next   = '0;
                    state_next = S_DONE;
                    pass_next  = (sig_next == GOLDEN);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign STIM = stim_q;
    assign SIG  = sig_q;
    assign PASS = pass_q;
    assign BUSY = (state == S_RUN) || (state == S_FLUSH);
    assign DONE = (state == S_DONE);

endmodule

// File: tb/tb_bist_pattern_engine.sv
// Scoreboard bench for bist_pattern_engine: five instances cover loopback, latency
// alignment, mis-set latency, LFSR sequence with mid-run reset, and the zero-seed case.
module tb_bist_pattern_engine;

    typedef struct {
        int         id;
        logic [7:0] sig;
        logic       pass;
        int         busy;
    } res_t;

    logic       C = 1'b0;
    logic       rst;
    logic       rst_d;
    logic       mon_en;
    logic       start  [5];
    logic [7:0] golden [5];
    logic [7:0] resp   [5];
    logic [7:0] stim   [5];
    logic [7:0] sig    [5];
    logic       busy   [5];
    logic       done   [5];
    logic       pass   [5];
    logic [7:0] d1_b, d2_b, d1_c, d2_c;

    logic [7:0] stim_q3 [$];
    logic [7:0] stim_q4 [$];
    logic [7:0] sig_q0  [$];
    res_t       res_q   [$];

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 C = ~C;

    // Register-pair DUT model shared by the LAT=2 and LAT=1 instances.
    always @(posedge C) begin
        d1_b <= stim[1];
        d2_b <= d1_b;
        d1_c <= stim[2];
        d2_c <= d1_c;
    end

    assign resp[0] = stim[0];
    assign resp[1] = d2_b;
    assign resp[2] = d2_c;
    assign resp[3] = stim[3];
    assign resp[4] = stim[4];

    bist_pattern_engine #(.WIDTH(8), .NPAT(3), .LAT(0)) u_loop (
        .C(C), .R(rst), .START(start[0]), .GOLDEN(golden[0]), .RESP(resp[0]),
        .STIM(stim[0]), .BUSY(busy[0]), .DONE(done[0]), .SIG(sig[0]), .PASS(pass[0]));

    bist_pattern_engine #(.WIDTH(8), .NPAT(3), .LAT(2)) u_lat2 (
        .C(C), .R(rst), .START(start[1]), .GOLDEN(golden[1]), .RESP(resp[1]),
        .STIM(stim[1]), .BUSY(busy[1]), .DONE(done[1]), .SIG(sig[1]), .PASS(pass[1]));

    bist_pattern_engine #(.WIDTH(8), .NPAT(3), .LAT(1)) u_lat1 (
        .C(C), .R(rst), .START(start[2]), .GOLDEN(golden[2]), .RESP(resp[2]),
        .STIM(stim[2]), .BUSY(busy[2]), .DONE(done[2]), .SIG(sig[2]), .PASS(pass[2]));

    bist_pattern_engine #(.WIDTH(8), .NPAT(6), .LAT(0)) u_lfsr (
        .C(C), .R(rst || rst_d), .START(start[3]), .GOLDEN(golden[3]), .RESP(resp[3]),
        .STIM(stim[3]), .BUSY(busy[3]), .DONE(done[3]), .SIG(sig[3]), .PASS(pass[3]));

    bist_pattern_engine #(.WIDTH(8), .NPAT(2), .LAT(0), .SEED(8'h00)) u_seed0 (
        .C(C), .R(rst), .START(start[4]), .GOLDEN(golden[4]), .RESP(resp[4]),
        .STIM(stim[4]), .BUSY(busy[4]), .DONE(done[4]), .SIG(sig[4]), .PASS(pass[4]));

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reportFail(input string name);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: event not expected / not seen at %0t", name, $time);
    endtask

    task automatic applyStimulus(input int id, input logic [7:0] g);
        @(negedge C);
        golden[id] = g;
        start[id]  = 1'b1;
        @(negedge C);
        start[id]  = 1'b0;
    endtask

    task automatic waitDone(input int id);
        int k = 0;
        while (!done[id] && k < 60) begin
            @(negedge C);
            k++;
        end
        if (!done[id]) reportFail($sformatf("done_timeout_%0d", id));
    endtask

    // Monitor: pops expectations whenever an instance presents a pattern, a signature
    // step, or a completed run.
    initial begin
        logic busy_prev [5];
        logic done_prev [5];
        int   bcnt      [5];
        res_t r;
        for (int i = 0; i < 5; i++) begin
            busy_prev[i] = 1'b0;
            done_prev[i] = 1'b0;
            bcnt[i]      = 0;
        end
        forever begin
            @(negedge C);
            if (mon_en) begin
                for (int i = 0; i < 5; i++) begin
                    if (busy[i] && !busy_prev[i]) bcnt[i] = 1;
                    else if (busy[i]) bcnt[i]++;
                    if (done[i] && !done_prev[i]) begin
                        if (res_q.size() == 0) begin
                            reportFail($sformatf("done_unexpected_%0d", i));
                        end else begin
                            r = res_q.pop_front();
                            checkOutput("result_id", i, r.id);
                            checkOutput($sformatf("final_sig_%0d", i), 32'(sig[i]), 32'(r.sig));
                            checkOutput($sformatf("pass_%0d", i), 32'(pass[i]), 32'(r.pass));
                            checkOutput($sformatf("busy_cycles_%0d", i), bcnt[i], r.busy);
                        end
                    end
                end
                if (busy[3]) begin
                    if (stim_q3.size() == 0) reportFail("stim_unexpected_3");
                    else checkOutput("lfsr_stim", 32'(stim[3]), 32'(stim_q3.pop_front()));
                end
                if (busy[4]) begin
                    if (stim_q4.size() == 0) reportFail("stim_unexpected_4");
                    else checkOutput("seed0_stim", 32'(stim[4]), 32'(stim_q4.pop_front()));
                end
                if (busy_prev[0]) begin
                    if (sig_q0.size() == 0) reportFail("sig_unexpected_0");
                    else checkOutput("loop_sig_step", 32'(sig[0]), 32'(sig_q0.pop_front()));
                end
                for (int i = 0; i < 5; i++) begin
                    busy_prev[i] = busy[i];
                    done_prev[i] = done[i];
                end
            end
        end
    end

    initial begin
        rst    = 1'b1;
        rst_d  = 1'b0;
        mon_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start[i]  = 1'b0;
            golden[i] = 8'h00;
        end
        repeat (2) @(negedge C);
        rst    = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("reset_state_%0d", i),
                        32'({stim[i], sig[i], busy[i], done[i], pass[i]}),
                        32'({8'h01, 8'h00, 3'b000}));
        end

        // LFSR sequence, loopback signature of six patterns folds back to 00
        foreach (stim_q3[i]) stim_q3.delete(i);
        stim_q3.push_back(8'h01); stim_q3.push_back(8'hB8); stim_q3.push_back(8'h5C);
        stim_q3.push_back(8'h2E); stim_q3.push_back(8'h17); stim_q3.push_back(8'hB3);
        res_q.push_back('{3, 8'h00, 1'b1, 6});
        applyStimulus(3, 8'h00);
        waitDone(3);

        // Reset while pattern 2 is on STIM
        stim_q3.push_back(8'h01); stim_q3.push_back(8'hB8); stim_q3.push_back(8'h5C);
        applyStimulus(3, 8'h00);
        @(negedge C);
        @(negedge C);
        rst_d = 1'b1;
        @(negedge C);
        rst_d = 1'b0;
        checkOutput("midrun_reset", 32'({stim[3], sig[3], busy[3], done[3], pass[3]}),
                    32'({8'h01, 8'h00, 3'b000}));
        repeat (3) @(negedge C);
        checkOutput("reset_holds_idle", 32'({stim[3], busy[3], done[3]}), 32'({8'h01, 2'b00}));

        // Loopback signature, then a restart from DONE with a wrong golden value
        sig_q0.push_back(8'h01); sig_q0.push_back(8'h00); sig_q0.push_back(8'h5C);
        res_q.push_back('{0, 8'h5C, 1'b1, 3});
        applyStimulus(0, 8'h5C);
        waitDone(0);
        sig_q0.push_back(8'h01); sig_q0.push_back(8'h00); sig_q0.push_back(8'h5C);
        res_q.push_back('{0, 8'h5C, 1'b0, 3});
        applyStimulus(0, 8'h5D);
        checkOutput("restart_clears", 32'({sig[0], done[0], pass[0], busy[0]}),
                    32'({8'h00, 3'b001}));
        waitDone(0);

        // Two-register DUT with LAT=2, then again with START pulses in RUN and FLUSH
        res_q.push_back('{1, 8'h5C, 1'b1, 5});
        applyStimulus(1, 8'h5C);
        waitDone(1);
        res_q.push_back('{1, 8'h5C, 1'b1, 5});
        applyStimulus(1, 8'h5C);
        checkOutput("lat2_restart", 32'({sig[1], done[1], busy[1]}), 32'({8'h00, 2'b01}));
        @(negedge C); start[1] = 1'b1;
        @(negedge C); start[1] = 1'b0;
        @(negedge C); start[1] = 1'b1;
        @(negedge C); start[1] = 1'b0;
        waitDone(1);

        // Same DUT with LAT=1: responses are taken one cycle early. The first run
        // absorbs 01,01,B8 (idle STIM is the seed) and lands on 5C by coincidence;
        // the second starts from STIM=2E, absorbs 2E,01,B8 and gives B3.
        res_q.push_back('{2, 8'h5C, 1'b1, 4});
        applyStimulus(2, 8'h5C);
        waitDone(2);
        res_q.push_back('{2, 8'hB3, 1'b0, 4});
        applyStimulus(2, 8'h5C);
        waitDone(2);

        // Zero seed is replaced by 1
        stim_q4.push_back(8'h01); stim_q4.push_back(8'hB8);
        res_q.push_back('{4, 8'h00, 1'b1, 2});
        applyStimulus(4, 8'h00);
        waitDone(4);

        repeat (3) @(negedge C);
        checkOutput("results_left", res_q.size(), 0);
        checkOutput("stim3_left", stim_q3.size(), 0);
        checkOutput("stim4_left", stim_q4.size(), 0);
        checkOutput("sig0_left", sig_q0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
